// File: rtl/vec_alu_seq_if.sv
// Operand/result bundle for vec_alu_seq: valid/ready on both the issue and result sides.
// The master drives operands and out_ready. The slave (the ALU) drives results and in_ready.
// The ovf lane flags exist only in the VEC_ALU_SAT_EN build.
interface vec_alu_seq_if #(
  parameter int LANES = 16,
  parameter int WIDTH = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic [2:0]                  op;
  logic [LANES-1:0]            lane_mask;
  logic [LANES-1:0][WIDTH-1:0] a;
  logic [LANES-1:0][WIDTH-1:0] b;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0][WIDTH-1:0] result;
  logic [LANES-1:0]            dz;
  logic                        op_err;
`ifdef VEC_ALU_SAT_EN
  logic [LANES-1:0]            ovf;

  modport master (output in_valid, op, lane_mask, a, b, out_ready,
                  input  in_ready, out_valid, result, dz, op_err, ovf);
  modport slave  (input  in_valid, op, lane_mask, a, b, out_ready,
                  output in_ready, out_valid, result, dz, op_err, ovf);
`else
  modport master (output in_valid, op, lane_mask, a, b, out_ready,
                  input  in_ready, out_valid, result, dz, op_err);
  modport slave  (input  in_valid, op, lane_mask, a, b, out_ready,
                  output in_ready, out_valid, result, dz, op_err);
`endif
endinterface

// File: rtl/vec_alu_seq.sv
// Handshaked LANES x WIDTH vector ALU (ADD/SUB/MOV/MUL, iterative DIV) with a per-lane write mask.
// Latency: 1 cycle for non-DIV and illegal ops, WIDTH+1 cycles for DIV (restoring, 1 bit/cycle).
// Backpressure: the result is held in HOLD until out_ready. in_ready = out_ready in HOLD, 0 in DIV_RUN.
// Build option VEC_ALU_SAT_EN: ADD/SUB/MUL saturate unsigned and the ovf lane flags are driven.
module vec_alu_seq #(
  parameter int LANES = 16,
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          reset,
  vec_alu_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_DIV_RUN, S_HOLD} state_t;

  state_t                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [LANES-1:0][WIDTH-1:0] a_q, b_q, quo_q, rem_q, result_q;
  logic [LANES-1:0]            mask_q, dz_q;
  logic                        op_err_q, out_valid_q;

  logic [LANES-1:0][WIDTH-1:0] alu_res_d, quo_d, rem_d, div_res_d;
  logic [LANES-1:0]            div_dz_d;
  logic [WIDTH:0]              rsh_w;
  logic                        accept;
`ifdef VEC_ALU_SAT_EN
  logic [LANES-1:0]            ovf_q, alu_ovf_d;
  logic [WIDTH:0]              sum_w, diff_w;
  logic [2*WIDTH-1:0]          prod_w;
`endif

  // A new bundle can enter when idle, or in HOLD when the current result leaves this cycle.
  assign bus.in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.dz        = dz_q;
  assign bus.op_err    = op_err_q;
`ifdef VEC_ALU_SAT_EN
  assign bus.ovf       = ovf_q;
`endif

  // Single-cycle lane results from the live inputs. MOV, masked lanes and illegal ops keep A.
  always_comb begin
    alu_res_d = bus.a;
`ifdef VEC_ALU_SAT_EN
    alu_ovf_d = '0;
    sum_w     = '0;
    diff_w    = '0;
    prod_w    = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
`ifdef VEC_ALU_SAT_EN
      sum_w  = {1'b0, bus.a[i]} + {1'b0, bus.b[i]};
      diff_w = {1'b0, bus.a[i]} - {1'b0, bus.b[i]};
      prod_w = (2*WIDTH)'(bus.a[i]) * (2*WIDTH)'(bus.b[i]);
`endif
      if (bus.lane_mask[i]) begin
        case (bus.op)
`ifdef VEC_ALU_SAT_EN
          OP_ADD: begin
            alu_res_d[i] = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
            alu_ovf_d[i] = sum_w[WIDTH];
          end
          OP_SUB: begin
            // The borrow bit doubles as the underflow flag.
            alu_res_d[i] = diff_w[WIDTH] ? '0 : diff_w[WIDTH-1:0];
            alu_ovf_d[i] = diff_w[WIDTH];
          end
          OP_MUL: begin
            alu_res_d[i] = (|prod_w[2*WIDTH-1:WIDTH]) ? '1 : prod_w[WIDTH-1:0];
            alu_ovf_d[i] = |prod_w[2*WIDTH-1:WIDTH];
          end
`else
          OP_ADD: alu_res_d[i] = bus.a[i] + bus.b[i];
          OP_SUB: alu_res_d[i] = bus.a[i] - bus.b[i];
          OP_MUL: alu_res_d[i] = bus.a[i] * bus.b[i];
`endif
          default: alu_res_d[i] = bus.a[i];
        endcase
      end
    end
  end

  // One restoring-division step per lane. The dividend shifts out of quo_q as quotient bits shift in.
  // A zero divisor always "fits", so its quotient naturally becomes all ones.
  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_res_d = a_q;
    div_dz_d  = '0;
    rsh_w     = '0;
    for (int i = 0; i < LANES; i++) begin
      rsh_w = {rem_q[i], quo_q[i][WIDTH-1]};
      if (rsh_w >= {1'b0, b_q[i]}) begin
        rem_d[i] = rsh_w[WIDTH-1:0] - b_q[i];
        quo_d[i] = {quo_q[i][WIDTH-2:0], 1'b1};
      end else begin
        rem_d[i] = rsh_w[WIDTH-1:0];
        quo_d[i] = {quo_q[i][WIDTH-2:0], 1'b0};
      end
      if (mask_q[i]) begin
        div_res_d[i] = quo_d[i];
        div_dz_d[i]  = (b_q[i] == '0);
      end
    end
  end

  // Control FSM together with the divider state and the registered result bundle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mask_q      <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      dz_q        <= '0;
      op_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef VEC_ALU_SAT_EN
      ovf_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_DIV_RUN: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          if (cnt_q == '0) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
            result_q    <= div_res_d;
            dz_q        <= div_dz_d;
            op_err_q    <= 1'b0;
`ifdef VEC_ALU_SAT_EN
            ovf_q       <= '0;
`endif
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          // S_IDLE and S_HOLD: an accept in HOLD implies out_ready, so the old result has left.
          if (accept) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            mask_q <= bus.lane_mask;
            if (bus.op == OP_DIV) begin
              state_q     <= S_DIV_RUN;
              cnt_q       <= CW'(WIDTH - 1);
              quo_q       <= bus.a;
              rem_q       <= '0;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              result_q    <= alu_res_d;
              dz_q        <= '0;
              op_err_q    <= (bus.op > OP_DIV);
`ifdef VEC_ALU_SAT_EN
              ovf_q       <= alu_ovf_d;
`endif
            end
          end else if ((state_q == S_HOLD) && bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq: directed cases plus a short random run.
// Expected bundles are computed by a behavioural model at issue time and queued.
// A negedge monitor pops and compares every transferred result; it also checks that stalled outputs hold.
module tb_vec_alu_seq;
  localparam int L = 16;
  localparam int W = 16;

  typedef logic [L-1:0][W-1:0] vec_t;
  typedef struct {
    vec_t         res;
    logic [L-1:0] dz;
    logic         err;
    logic [L-1:0] ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  vec_alu_seq_if #(.LANES(L), .WIDTH(W)) bus ();
  vec_alu_seq #(.LANES(L), .WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [L-1:0] m, input vec_t a, input vec_t b);
    exp_t e;
    longint r;
    e.res = a;
    e.dz  = '0;
    e.err = (op > 3'd4);
    e.ovf = '0;
    for (int i = 0; i < L; i++) begin
      if (m[i] && op <= 3'd4) begin
        case (op)
          3'd0:    r = longint'(a[i]) + longint'(b[i]);
          3'd1:    r = longint'(a[i]) - longint'(b[i]);
          3'd3:    r = longint'(a[i]) * longint'(b[i]);
          3'd4:    r = (b[i] == 0) ? 65535 : longint'(a[i]) / longint'(b[i]);
          default: r = longint'(a[i]);
        endcase
        if (op == 3'd4 && b[i] == 0) e.dz[i] = 1'b1;
`ifdef VEC_ALU_SAT_EN
        if (r > 65535) begin r = 65535; e.ovf[i] = 1'b1; end
        if (r < 0)     begin r = 0;     e.ovf[i] = 1'b1; end
`endif
        e.res[i] = W'(r);
      end
    end
    return e;
  endfunction

  // Scoreboard monitor: compare each transfer and check that stalled outputs stay put.
  initial begin
    exp_t e;
    logic stall_prev = 1'b0;
    vec_t res_prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", bus.out_valid, 1'b1);
          check("hold_result", bus.result, res_prev);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_out", 1'b1, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check("sb_result", bus.result, e.res);
            check("sb_dz", bus.dz, e.dz);
            check("sb_op_err", bus.op_err, e.err);
`ifdef VEC_ALU_SAT_EN
            check("sb_ovf", bus.ovf, e.ovf);
`endif
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        res_prev   = bus.result;
      end
    end
  end

  // Present a bundle, queue its expected result, and hold it until the accept edge.
  task automatic drive(input logic [2:0] op, input logic [L-1:0] m, input vec_t a, input vec_t b);
    int n = 0;
    bus.op = op; bus.lane_mask = m; bus.a = a; bus.b = b;
    bus.in_valid = 1'b1;
    sb_q.push_back(model(op, m, a, b));
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Issue one bundle with out_ready high and check accept-to-out_valid latency.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [L-1:0] m,
                         input vec_t a, input vec_t b, input int exp_lat);
    int lat = 0;
    drive(op, m, a, b);
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check(tag, lat, exp_lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t a, b;
    exp_t e;
    int   lat;
    bus.in_valid = 1'b0; bus.op = '0; bus.lane_mask = '0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;

    // Reset values
    #12;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.result, '0);
    check("rst_dz", bus.dz, '0);
    check("rst_op_err", bus.op_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1. ADD, latency 1
    a = '0; b = '0;
    a[0] = 200; a[1] = 254; a[2] = 251; a[3] = 200; a[4] = 5; a[5] = 10; a[6] = 100; a[7] = 15;
    b[0] = 100; b[1] = 1;   b[2] = 1;   b[3] = 45;  b[4] = 25; b[5] = 1; b[6] = 2;   b[7] = 10;
    run_one("add_lat", 3'd0, '1, a, b, 1);
    check("add_lane0", bus.result[0], 16'd300);
    check("add_lane1", bus.result[1], 16'd255);

    // 2. SUB below zero
    a = '0; b = '0; a[0] = 5; b[0] = 10;
    run_one("sub_lat", 3'd1, '1, a, b, 1);
`ifdef VEC_ALU_SAT_EN
    check("sub_sat_lane0", bus.result[0], 16'd0);
    check("sub_sat_ovf", bus.ovf[0], 1'b1);
`else
    check("sub_wrap_lane0", bus.result[0], 16'd65531);
`endif

    // 3. DIV, latency WIDTH+1, divide by zero in lane 8
    for (int i = 0; i < L; i++) begin a[i] = 0; b[i] = 1; end
    a[0] = 2; a[1] = 6; a[2] = 10; a[3] = 15; a[4] = 200; a[5] = 8; a[6] = 25; a[7] = 50; a[8] = 7;
    b[0] = 2; b[1] = 2; b[2] = 2;  b[3] = 2;  b[4] = 100; b[5] = 4; b[6] = 5;  b[7] = 2;  b[8] = 0;
    run_one("div_lat", 3'd4, '1, a, b, 17);
    check("div_lane3", bus.result[3], 16'd7);
    check("div_lane7", bus.result[7], 16'd25);
    check("div_lane8_dz", bus.result[8], 16'd65535);
    check("div_dz_vec", bus.dz, 16'h0100);

    // 4. Masked MUL under 5 cycles of backpressure
    for (int i = 0; i < L; i++) begin a[i] = W'(i + 1); b[i] = 3; end
    e = model(3'd3, 16'h00FF, a, b);
    bus.out_ready = 1'b0;
    drive(3'd3, 16'h00FF, a, b);
    @(negedge clk);
    check("mul_lat", bus.out_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_result", bus.result, e.res);
      check("bp_in_ready", bus.in_ready, 1'b0);
      if (k < 4) @(negedge clk);
    end
    check("mul_lane2", bus.result[2], 16'd9);
    check("mul_masked_lane9", bus.result[9], 16'd10);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // 5. Back-to-back ADD then MOV
    for (int i = 0; i < L; i++) begin a[i] = W'(100 * i); b[i] = W'(i); end
    bus.op = 3'd0; bus.lane_mask = '1; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    sb_q.push_back(model(3'd0, '1, a, b));
    @(posedge clk);
    #1;
    for (int i = 0; i < L; i++) begin a[i] = W'(7 * i + 3); b[i] = 16'hFFFF; end
    bus.op = 3'd2; bus.a = a; bus.b = b;
    sb_q.push_back(model(3'd2, '1, a, b));
    @(negedge clk);
    check("b2b_valid0", bus.out_valid, 1'b1);
    check("b2b_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid1", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;

    // 6. Reset in the middle of a DIV, then ADD recovers with latency 1
    for (int i = 0; i < L; i++) begin a[i] = W'(1000 + i); b[i] = W'(i + 2); end
    drive(3'd4, '1, a, b);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 1'b0);
    check("rst_mid_in_ready", bus.in_ready, 1'b1);
    check("rst_mid_result", bus.result, '0);
    check("rst_mid_dz", bus.dz, '0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < L; i++) begin a[i] = W'(i); b[i] = W'(2 * i); end
    run_one("post_rst_add_lat", 3'd0, '1, a, b, 1);

    // Random ops, including illegal codes and zero divisors
    for (int n = 0; n < 12; n++) begin
      logic [2:0] op;
      logic [L-1:0] m;
      op = 3'($urandom_range(0, 7));
      m  = L'($urandom);
      for (int i = 0; i < L; i++) begin
        a[i] = W'($urandom);
        b[i] = (op == 3'd4) ? W'($urandom_range(0, 300)) : W'($urandom);
      end
      lat = (op == 3'd4) ? 17 : 1;
      run_one("rand_lat", op, m, a, b, lat);
    end

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
